mdu_iter: RTL and testbench

Parametrised iterative multiply/divide unit with HI/LO accumulator registers for the pipelined MIPS core. It sits in the EX stage, accepts one operation per `start` pulse, and holds `busy` while a multi-cycle operation runs. It supports signed/unsigned multiply, divide, multiply-accumulate and multiply-subtract, and direct HI/LO writes. Results land in HI/LO and are read back through a combinational select port gated by the exception request.

---
 rtl/mdu_iter.sv | 179 +++++++++++++++++
 tb/tb_mdu_iter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit with HI/LO accumulator registers.
// Multiplies finish after a fixed MUL_LAT busy cycles. Divides run one
// restoring step per cycle for WIDTH cycles, then spend one FIX cycle
// applying signs. Results are read through a combinational HI/LO select
// that is forced to zero while an exception request is pending.
//
// Handshake: start is a one-cycle issue strobe. It is accepted only when the
// unit is IDLE and req is low. busy goes high combinationally in the issue
// cycle of any multi-cycle op, and stays high until the cycle before the new
// HI/LO value becomes readable. The issuer must hold off while busy is high.
module mdu_iter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [1:0]       read_sel,
  input  logic             req,
  output logic             busy,
  output logic [WIDTH-1:0] result
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 16);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] opa;       // multiplicand, or dividend/quotient shift register
  logic [WIDTH-1:0] opb;       // multiplier, or divisor magnitude
  logic [WIDTH-1:0] rem;       // partial remainder
  logic [WIDTH-1:0] a_raw;     // raw dividend, returned in HI on divide by zero
  logic [CW-1:0]    cnt;
  logic             mul_signed;
  logic [1:0]       acc_mode;  // 0 load, 1 add, 2 subtract
  logic             neg_q, neg_r, div_zero;

  logic issue_ok, is_mul, is_div;
  logic [W2-1:0] ext_a, ext_b, product, hilo;
  logic [WIDTH:0] rem_shift;
  logic take;
  logic [WIDTH-1:0] rem_sub;
  logic div_signed, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  // Decode the issue and the operand preprocessing for both paths
  always_comb begin
    issue_ok   = start & ~req & (state == IDLE);
    is_mul     = (op == 4'd1) | (op == 4'd2) | (op == 4'd5) |
                 (op == 4'd6) | (op == 4'd7) | (op == 4'd8);
    is_div     = (op == 4'd3) | (op == 4'd4);
    div_signed = (op == 4'd3);
    a_neg      = div_signed & src_a[WIDTH-1];
    b_neg      = div_signed & src_b[WIDTH-1];
    mag_a      = a_neg ? (~src_a + 1'b1) : src_a;
    mag_b      = b_neg ? (~src_b + 1'b1) : src_b;
    busy       = (state != IDLE) | (start & (op >= 4'd1) & (op <= 4'd8));
  end

  // Product of the latched operands and one restoring-division step
  always_comb begin
    ext_a     = mul_signed ? {{WIDTH{opa[WIDTH-1]}}, opa} : {{WIDTH{1'b0}}, opa};
    ext_b     = mul_signed ? {{WIDTH{opb[WIDTH-1]}}, opb} : {{WIDTH{1'b0}}, opb};
    product   = ext_a * ext_b;
    hilo      = {hi, lo};
    rem_shift = {rem, opa[WIDTH-1]};
    take      = (rem_shift >= {1'b0, opb});
    rem_sub   = WIDTH'(rem_shift - {1'b0, opb});
  end

  // Next-state logic for the sequencing FSM
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (issue_ok && is_mul)      state_next = MUL;
        else if (issue_ok && is_div) state_next = DIV;
      end
      MUL:     if (cnt == '0) state_next = IDLE;
      DIV:     if (cnt == '0) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Datapath: operand capture, iteration and HI/LO writeback
  always_ff @(posedge clk) begin
    if (reset) begin
      hi         <= '0;
      lo         <= '0;
      opa        <= '0;
      opb        <= '0;
      rem        <= '0;
      a_raw      <= '0;
      cnt        <= '0;
      mul_signed <= 1'b0;
      acc_mode   <= 2'd0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue_ok) begin
            if (is_mul) begin
              opa        <= src_a;
              opb        <= src_b;
              mul_signed <= (op == 4'd1) | (op == 4'd5) | (op == 4'd7);
              acc_mode   <= ((op == 4'd5) | (op == 4'd6)) ? 2'd1 :
                            ((op == 4'd7) | (op == 4'd8)) ? 2'd2 : 2'd0;
              cnt        <= CW'(MUL_LAT - 1);
            end else if (is_div) begin
              opa      <= mag_a;
              opb      <= mag_b;
              rem      <= '0;
              neg_q    <= a_neg ^ b_neg;
              neg_r    <= a_neg;
              div_zero <= (src_b == '0);
              a_raw    <= src_a;
              cnt      <= CW'(WIDTH - 1);
            end else if (op == 4'd9) begin
              hi <= src_a;
            end else if (op == 4'd10) begin
              lo <= src_a;
            end
          end
        end
        MUL: begin
          if (cnt == '0) begin
            case (acc_mode)
              2'd1:    {hi, lo} <= hilo + product;
              2'd2:    {hi, lo} <= hilo - product;
              default: {hi, lo} <= product;
            endcase
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DIV: begin
          opa <= {opa[WIDTH-2:0], take};
          rem <= take ? rem_sub : rem_shift[WIDTH-1:0];
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: begin
          if (div_zero) begin
            lo <= '1;
            hi <= a_raw;
          end else begin
            lo <= neg_q ? (~opa + 1'b1) : opa;
            hi <= neg_r ? (~rem + 1'b1) : rem;
          end
        end
        default: ;
      endcase
    end
  end

  // Read port: HI/LO select, suppressed during an exception request
  always_comb begin
    result = '0;
    if (!req) begin
      if (read_sel == 2'b10)      result = hi;
      else if (read_sel == 2'b01) result = lo;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed and randomized checks of mdu_iter against an
// arithmetic reference model of HI/LO.
module tb_mdu_iter;

  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 5;

  logic              clk;
  logic              reset;
  logic [WIDTH-1:0]  src_a, src_b;
  logic              start;
  logic [3:0]        op;
  logic [1:0]        read_sel;
  logic              req;
  logic              busy;
  logic [WIDTH-1:0]  result;

  logic [31:0] m_hi, m_lo;
  int n_cmp, n_err;

  mdu_iter #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .src_a(src_a), .src_b(src_b), .start(start),
    .op(op), .read_sel(read_sel), .req(req), .busy(busy), .result(result)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reads HI, LO and the null selection and compares them with given values
  task automatic check_hilo(input string tag, input logic [31:0] hi_e, input logic [31:0] lo_e);
    read_sel = 2'b10; #1;
    check({tag, "_hi"}, 64'(result), 64'(hi_e));
    read_sel = 2'b01; #1;
    check({tag, "_lo"}, 64'(result), 64'(lo_e));
    read_sel = 2'b11; #1;
    check({tag, "_sel11"}, 64'(result), 64'd0);
  endtask

  // Reference model: the architectural effect of one issued operation
  task automatic model_update(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa64, sb64;
    longint unsigned ua64, ub64, hl, sp, up;
    int sa, sb;
    sa64 = longint'($signed(a));
    sb64 = longint'($signed(b));
    ua64 = {32'd0, a};
    ub64 = {32'd0, b};
    sp   = longint'(sa64 * sb64);
    up   = ua64 * ub64;
    hl   = {m_hi, m_lo};
    sa   = a;
    sb   = b;
    case (o)
      4'd1: hl = sp;
      4'd2: hl = up;
      4'd5: hl = hl + sp;
      4'd6: hl = hl + up;
      4'd7: hl = hl - sp;
      4'd8: hl = hl - up;
      default: ;
    endcase
    if (o inside {4'd1, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8}) begin
      m_hi = hl[63:32];
      m_lo = hl[31:0];
    end else if (o == 4'd3 || o == 4'd4) begin
      if (b == 32'd0) begin
        m_lo = 32'hFFFF_FFFF;
        m_hi = a;
      end else if (o == 4'd3 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        m_lo = 32'h8000_0000;
        m_hi = 32'd0;
      end else if (o == 4'd3) begin
        m_lo = sa / sb;
        m_hi = sa % sb;
      end else begin
        m_lo = a / b;
        m_hi = a % b;
      end
    end else if (o == 4'd9) begin
      m_hi = a;
    end else if (o == 4'd10) begin
      m_lo = a;
    end
  endtask

  // Driver: issue one op at the current cycle, measure busy, then check HI/LO
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    int cnt, exp_cnt;
    bit multi;
    multi = (o >= 4'd1 && o <= 4'd8);
    op = o; src_a = a; src_b = b; start = 1'b1; #1;
    check("busy_issue", 64'(busy), 64'(multi));
    cnt = busy ? 1 : 0;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    read_sel = 2'b10; #1;
    if (multi) check("hold_hi", 64'(result), 64'(m_hi));
    while (busy && cnt < 200) begin
      cnt++;
      @(posedge clk); #1;
    end
    model_update(o, a, b);
    if (o == 4'd3 || o == 4'd4) exp_cnt = WIDTH + 2;
    else if (multi)             exp_cnt = MUL_LAT + 1;
    else                        exp_cnt = 0;
    check("busy_cycles", 64'(cnt), 64'(exp_cnt));
    check_hilo("model", m_hi, m_lo);
  endtask

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    n_cmp = 0; n_err = 0;
    m_hi = 32'd0; m_lo = 32'd0;
    reset = 1'b1; start = 1'b0; op = 4'd0; src_a = '0; src_b = '0;
    read_sel = 2'b00; req = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1; reset = 1'b0; #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check_hilo("reset", 32'd0, 32'd0);

    // Signed and unsigned multiply
    run_op(4'd1, 32'hFFFF_FFFE, 32'd3);
    check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op(4'd2, 32'hFFFF_FFFE, 32'd3);
    check_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);

    // Divides including divide by zero and signed overflow
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2);
    check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(4'd4, 32'd7, 32'd0);
    check_hilo("divu0", 32'd7, 32'hFFFF_FFFF);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    check_hilo("div_ovf", 32'd0, 32'h8000_0000);

    // Direct writes, then accumulate with carry and subtract with borrow
    run_op(4'd9, 32'd0, 32'd0);
    run_op(4'd10, 32'hFFFF_FFFF, 32'd0);
    run_op(4'd6, 32'd1, 32'd1);
    check_hilo("maddu", 32'd1, 32'd0);
    run_op(4'd7, 32'd1, 32'd1);
    check_hilo("msub", 32'd0, 32'hFFFF_FFFF);

    // Issue suppressed by req
    run_op(4'd9, 32'h1234_5678, 32'd0);
    req = 1'b1; op = 4'd1; src_a = 32'd5; src_b = 32'd7; start = 1'b1;
    read_sel = 2'b10; #1;
    check("req_busy_t", 64'(busy), 64'd1);
    check("req_result", 64'(result), 64'd0);
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0; #1;
    check("req_busy_t1", 64'(busy), 64'd0);
    check("req_result_t1", 64'(result), 64'd0);
    req = 1'b0;
    @(posedge clk); #1;
    check("req_busy_t2", 64'(busy), 64'd0);
    check_hilo("req_unchanged", 32'h1234_5678, 32'hFFFF_FFFF);

    // Reset aborting a divide in flight
    op = 4'd3; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; op = 4'd0;
    repeat (9) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; #1;
    check("abort_busy", 64'(busy), 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    check_hilo("abort", 32'd0, 32'd0);
    run_op(4'd2, 32'd3, 32'd4);
    check_hilo("after_abort", 32'd0, 32'd12);

    // Randomized back-to-back operations against the model
    for (int i = 0; i < 60; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 20));
        default: ;
      endcase
      run_op(ro, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
